// File: rtl/mmu_arb.sv
// mmu_arb: arbitrates the I and D ports onto one memory port, applying per-thread base/limit translation.
module mmu_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_TRD = 8,
  localparam int TRD_W = $clog2(NUM_TRD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [TRD_W-1:0]  cfg_trd,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic [TRD_W-1:0]  i_trd,
  output logic [DATA_W-1:0] i_rd_data,
  output logic              i_miss,
  output logic              i_done,
  output logic              i_segfault,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [TRD_W-1:0]  d_trd,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_miss,
  output logic              d_done,
  output logic              d_segfault,
  output logic [1:0]        mem_opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rdy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FAULT} state_t;
  state_t state;
  logic [ADDR_W-1:0] base [NUM_TRD];
  logic [ADDR_W-1:0] limit [NUM_TRD];
  logic owner_d, last_d, i_req, d_req, pick_d, fault, is_wr;
  logic [TRD_W-1:0] trd;
  logic [ADDR_W-1:0] vaddr, phys;
  always_comb begin
    i_req = i_rd && !i_done && !i_segfault;
    d_req = (d_rd || d_wr) && !d_done && !d_segfault;
    pick_d = d_req && (!i_req || !last_d);
    trd = pick_d ? d_trd : i_trd;
    vaddr = pick_d ? d_addr : i_addr;
    phys = base[trd] + vaddr;
    fault = (vaddr >= limit[trd]) || (pick_d && d_rd && d_wr);
    is_wr = pick_d && d_wr;
  end
  assign i_miss = i_rd && !(state != IDLE && !owner_d) && !i_done && !i_segfault;
  assign d_miss = (d_rd || d_wr) && !(state != IDLE && owner_d) && !d_done && !d_segfault;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner_d <= 1'b0;
      last_d <= 1'b0;
      mem_opcode <= 2'b00;
      mem_addr <= '0;
      mem_wr_data <= '0;
      i_rd_data <= '0;
      d_rd_data <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_segfault <= 1'b0;
      d_segfault <= 1'b0;
      for (int k = 0; k < NUM_TRD; k++) begin
        base[k] <= '0;
        limit[k] <= '0;
      end
    end else begin
      if (cfg_wr) begin
        base[cfg_trd] <= cfg_base;
        limit[cfg_trd] <= cfg_limit;
      end
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_segfault <= 1'b0;
      d_segfault <= 1'b0;
      case (state)
        IDLE: if (i_req || d_req) begin
          owner_d <= pick_d;
          last_d <= pick_d;
          if (fault) begin
            state <= FAULT;
            i_segfault <= !pick_d;
            d_segfault <= pick_d;
          end else begin
            state <= is_wr ? WRITE : READ;
            mem_opcode <= is_wr ? 2'b11 : 2'b01;
            mem_addr <= phys;
            if (is_wr) mem_wr_data <= d_wr_data;
          end
        end
        READ, WRITE: if (mem_rdy) begin
          state <= IDLE;
          mem_opcode <= 2'b00;
          if (state == READ && owner_d) d_rd_data <= mem_rd_data;
          if (state == READ && !owner_d) i_rd_data <= mem_rd_data;
          i_done <= !owner_d;
          d_done <= owner_d;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_arb.sv
// tb_mmu_arb: randomized and directed self-checking bench for mmu_arb against a base/limit reference model.
module tb_mmu_arb;
  logic clk = 0, rst;
  logic cfg_wr;
  logic [2:0] cfg_trd, i_trd, d_trd;
  logic [31:0] cfg_base, cfg_limit, i_addr, d_addr, d_wr_data, mem_rd_data;
  logic i_rd, d_rd, d_wr, mem_rdy;
  logic [31:0] i_rd_data, d_rd_data, mem_addr, mem_wr_data;
  logic i_miss, i_done, i_segfault, d_miss, d_done, d_segfault;
  logic [1:0] mem_opcode;
  logic [31:0] mbase [8];
  logic [31:0] mlimit [8];
  int passed = 0, total = 0;
  logic [1:0] ob_op;
  logic [31:0] ob_addr, ob_wdata, ob_rdata;
  logic ob_done, ob_seg, ob_pulse2, ob_timeout, ob_miss_pulse;
  int ob_cycles;
  int order [$];
  logic ob_imiss, ob_dmiss;
  always #5 clk = ~clk;
  mmu_arb dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_trd(cfg_trd), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd), .i_rd_data(i_rd_data), .i_miss(i_miss), .i_done(i_done),
    .i_segfault(i_segfault), .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data), .d_miss(d_miss), .d_done(d_done), .d_segfault(d_segfault), .mem_opcode(mem_opcode),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
  );
  task automatic do_reset();
    rst = 1;
    i_rd = 0; d_rd = 0; d_wr = 0; cfg_wr = 0; mem_rdy = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int t = 0; t < 8; t++) begin
      mbase[t] = 0;
      mlimit[t] = 0;
    end
  endtask
  task automatic cfg(input logic [2:0] t, input logic [31:0] b, input logic [31:0] l);
    cfg_wr = 1; cfg_trd = t; cfg_base = b; cfg_limit = l;
    @(negedge clk);
    cfg_wr = 0;
    mbase[t] = b;
    mlimit[t] = l;
  endtask
  task automatic txn(input bit pd, input bit rd, input bit wr, input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input logic [31:0] rdv, input bit mid,
                     input logic [31:0] mid_base);
    int cnt;
    bit fin;
    cnt = 0;
    fin = 0;
    i_rd = !pd && rd; i_trd = t; i_addr = a;
    d_rd = pd && rd; d_wr = pd && wr; d_trd = t; d_addr = a; d_wr_data = wd;
    ob_op = 0; ob_addr = 0; ob_wdata = 0; ob_done = 0; ob_seg = 0; ob_cycles = 0; ob_miss_pulse = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge clk);
      mem_rdy = 0;
      cfg_wr = 0;
      if (mem_opcode != 2'b00) begin
        ob_op = mem_opcode; ob_addr = mem_addr; ob_wdata = mem_wr_data;
        if (mid && cnt == 0) begin
          cfg_wr = 1; cfg_trd = t; cfg_base = mid_base; cfg_limit = mlimit[t];
          mbase[t] = mid_base;
          i_addr = a ^ 32'h4; d_addr = a ^ 32'h4; d_wr_data = ~wd;
        end
        if (cnt == dly) begin
          mem_rdy = 1;
          mem_rd_data = rdv;
        end
        cnt++;
      end
      ob_done = pd ? d_done : i_done;
      ob_seg = pd ? d_segfault : i_segfault;
      if (ob_done || ob_seg) begin
        fin = 1;
        ob_cycles = c + 1;
        ob_miss_pulse = pd ? d_miss : i_miss;
      end
    end
    ob_timeout = !fin;
    i_rd = 0; d_rd = 0; d_wr = 0; cfg_wr = 0; mem_rdy = 0;
    @(negedge clk);
    ob_pulse2 = pd ? (d_done | d_segfault) : (i_done | i_segfault);
    ob_rdata = pd ? d_rd_data : i_rd_data;
  endtask
  task automatic both_run();
    bit first_seen;
    first_seen = 0;
    order.delete();
    i_rd = 1; i_trd = 2; i_addr = 32'h8;
    d_wr = 1; d_rd = 0; d_trd = 2; d_addr = 32'hC; d_wr_data = 32'h55;
    for (int c = 0; c < 40 && order.size() < 2; c++) begin
      @(negedge clk);
      mem_rdy = 0;
      if (mem_opcode != 2'b00) begin
        if (!first_seen) begin
          ob_imiss = i_miss;
          ob_dmiss = d_miss;
          first_seen = 1;
        end
        mem_rdy = 1;
        mem_rd_data = 32'hA1;
      end
      if (d_done) begin
        order.push_back(1);
        d_wr = 0;
      end
      if (i_done) begin
        order.push_back(0);
        i_rd = 0;
      end
    end
    i_rd = 0; d_wr = 0; mem_rdy = 0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (mem_opcode !== 2'b00) $display("FAIL reset_opcode got %h exp 0", mem_opcode); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", mem_addr); else passed++;
    total++; if (mem_wr_data !== 32'h0) $display("FAIL reset_wdata got %h exp 0", mem_wr_data); else passed++;
    total++; if ({i_done, d_done, i_segfault, d_segfault, i_miss, d_miss} !== 6'b0) $display("FAIL reset_flags got %b exp 000000", {i_done, d_done, i_segfault, d_segfault, i_miss, d_miss}); else passed++;
    total++; if ({i_rd_data, d_rd_data} !== 64'h0) $display("FAIL reset_rdata got %h exp 0", {i_rd_data, d_rd_data}); else passed++;
  endtask
  task automatic test_arbitration();
    do_reset();
    cfg(2, 32'h1000, 32'h100);
    both_run();
    total++; if (order.size() != 2 || order[0] != 1 || order[1] != 0) $display("FAIL arb_order_first got size %0d first %0d exp D then I", order.size(), order.size() > 0 ? order[0] : -1); else passed++;
    total++; if ({ob_imiss, ob_dmiss} !== 2'b10) $display("FAIL arb_miss_first got i=%b d=%b exp i=1 d=0", ob_imiss, ob_dmiss); else passed++;
    txn(1, 1, 0, 2, 32'h4, 0, 0, 32'h33, 0, 0);
    both_run();
    total++; if (order.size() != 2 || order[0] != 0 || order[1] != 1) $display("FAIL arb_order_repeat got size %0d first %0d exp I then D", order.size(), order.size() > 0 ? order[0] : -1); else passed++;
    total++; if ({ob_imiss, ob_dmiss} !== 2'b01) $display("FAIL arb_miss_repeat got i=%b d=%b exp i=0 d=1", ob_imiss, ob_dmiss); else passed++;
  endtask
  task automatic test_basic_read();
    txn(0, 1, 0, 2, 32'h20, 0, 0, 32'hCAFE, 0, 0);
    total++; if (ob_op !== 2'b01) $display("FAIL read_opcode got %h exp 1", ob_op); else passed++;
    total++; if (ob_addr !== 32'h1020) $display("FAIL read_addr got %h exp 1020", ob_addr); else passed++;
    total++; if (ob_rdata !== 32'hCAFE) $display("FAIL read_data got %h exp cafe", ob_rdata); else passed++;
    total++; if ({ob_done, ob_pulse2, ob_miss_pulse} !== 3'b100) $display("FAIL read_done_pulse got %b exp 100", {ob_done, ob_pulse2, ob_miss_pulse}); else passed++;
    total++; if (ob_cycles != 2) $display("FAIL read_latency got %0d exp 2", ob_cycles); else passed++;
  endtask
  task automatic test_faults();
    txn(1, 0, 1, 2, 32'h100, 32'h9, 0, 0, 0, 0);
    total++; if ({ob_seg, ob_done, ob_pulse2, ob_op} !== 5'b10000) $display("FAIL limit_fault got %b exp 10000", {ob_seg, ob_done, ob_pulse2, ob_op}); else passed++;
    total++; if (ob_cycles != 1) $display("FAIL limit_fault_latency got %0d exp 1", ob_cycles); else passed++;
    txn(1, 1, 1, 2, 32'h10, 32'h9, 0, 0, 0, 0);
    total++; if ({ob_seg, ob_done, ob_pulse2, ob_op} !== 5'b10000) $display("FAIL rdwr_fault got %b exp 10000", {ob_seg, ob_done, ob_pulse2, ob_op}); else passed++;
  endtask
  task automatic test_write_and_wrap();
    txn(1, 1, 0, 2, 32'h40, 0, 1, 32'hBEEF, 0, 0);
    txn(1, 0, 1, 2, 32'h44, 32'h12345678, 2, 32'hDEAD, 0, 0);
    total++; if ({ob_op, ob_addr, ob_wdata} !== {2'b11, 32'h1044, 32'h12345678}) $display("FAIL write_bus got %h %h %h exp 3 1044 12345678", ob_op, ob_addr, ob_wdata); else passed++;
    total++; if (ob_rdata !== 32'hBEEF) $display("FAIL write_keeps_rdata got %h exp beef", ob_rdata); else passed++;
    cfg(5, 32'hFFFFFFF0, 32'h40);
    txn(0, 1, 0, 5, 32'h20, 0, 0, 32'h1, 0, 0);
    total++; if (ob_addr !== 32'h10) $display("FAIL wrap_addr got %h exp 10", ob_addr); else passed++;
  endtask
  task automatic test_inflight();
    cfg(3, 32'h2000, 32'h80);
    txn(0, 1, 0, 3, 32'h10, 0, 3, 32'h77, 1, 32'h9000);
    total++; if ({ob_addr, ob_rdata} !== {32'h2010, 32'h77}) $display("FAIL inflight_stable got %h %h exp 2010 77", ob_addr, ob_rdata); else passed++;
    txn(0, 1, 0, 3, 32'h10, 0, 0, 32'h78, 0, 0);
    total++; if (ob_addr !== 32'h9010) $display("FAIL new_base_visible got %h exp 9010", ob_addr); else passed++;
  endtask
  task automatic test_reset_mid();
    bit seen, done_seen;
    seen = 0;
    done_seen = 0;
    cfg(4, 32'h300, 32'h100);
    i_rd = 1; i_trd = 4; i_addr = 32'h40; mem_rdy = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (mem_opcode == 2'b01);
    end
    total++; if (!seen) $display("FAIL mid_reset_start got idle exp read"); else passed++;
    rst = 1;
    @(negedge clk);
    rst = 0;
    total++; if ({mem_opcode, mem_addr, i_done} !== 35'h0) $display("FAIL mid_reset_abort got %h %h %b exp 0 0 0", mem_opcode, mem_addr, i_done); else passed++;
    i_rd = 0;
    for (int t = 0; t < 8; t++) begin
      mbase[t] = 0;
      mlimit[t] = 0;
    end
    repeat (3) begin
      @(negedge clk);
      done_seen |= i_done;
    end
    total++; if (done_seen) $display("FAIL mid_reset_no_done got 1 exp 0"); else passed++;
    for (int t = 0; t < 8; t++) begin
      txn(t[0], 1, 0, 3'(t), 32'h0, 0, 0, 0, 0, 0);
      total++; if ({ob_seg, ob_op} !== 3'b100) $display("FAIL cleared_limit_%0d got seg=%b op=%h exp seg=1 op=0", t, ob_seg, ob_op); else passed++;
    end
  endtask
  task automatic test_random();
    logic [31:0] last_rd [2];
    last_rd[0] = i_rd_data;
    last_rd[1] = d_rd_data;
    for (int t = 0; t < 8; t++)
      cfg(3'(t), $urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(16, 512)));
    for (int n = 0; n < 40; n++) begin
      bit pd, rd, wr, f;
      int k, dly;
      logic [2:0] t;
      logic [31:0] a, wd, rdv, ph;
      pd = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 5);
      rd = !pd || k < 3 || k == 5;
      wr = pd && k >= 3;
      t = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, int'(mlimit[t]) + 16));
      wd = $urandom;
      rdv = $urandom;
      dly = $urandom_range(0, 3);
      f = (a >= mlimit[t]) || (rd && wr);
      ph = mbase[t] + a;
      txn(pd, rd, wr, t, a, wd, dly, rdv, 0, 0);
      if (!f && rd) last_rd[pd] = rdv;
      total++; if ({ob_timeout, ob_pulse2} !== 2'b00) $display("FAIL rnd%0d_term got to=%b p2=%b exp 0 0", n, ob_timeout, ob_pulse2); else passed++;
      total++; if ({ob_seg, ob_done} !== {f, !f}) $display("FAIL rnd%0d_result got seg=%b done=%b exp seg=%b", n, ob_seg, ob_done, f); else passed++;
      total++; if ({ob_op, ob_addr} !== (f ? 34'h0 : {(wr ? 2'b11 : 2'b01), ph})) $display("FAIL rnd%0d_bus got %h %h exp fault=%b addr %h", n, ob_op, ob_addr, f, ph); else passed++;
      total++; if (ob_rdata !== last_rd[pd]) $display("FAIL rnd%0d_rdata got %h exp %h", n, ob_rdata, last_rd[pd]); else passed++;
      if (wr && !f) begin
        total++; if (ob_wdata !== wd) $display("FAIL rnd%0d_wdata got %h exp %h", n, ob_wdata, wd); else passed++;
      end
    end
  endtask
  initial begin
    i_addr = 0; d_addr = 0; d_wr_data = 0; i_trd = 0; d_trd = 0; cfg_trd = 0; cfg_base = 0; cfg_limit = 0; mem_rd_data = 0;
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_basic_read();
    test_faults();
    test_write_and_wrap();
    test_inflight();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
